// File: rtl/dm_sba_resp.sv
// Single-outstanding SRAM bus slave: req/gnt request phase, one-cycle r_valid response.
// Define DM_SBA_RESP_RANGE_ERR_EN to reject out-of-range addresses with r_err instead of wrapping.
module dm_sba_resp #(
    parameter int BusWidth   = 32,
    parameter int Depth      = 256,
    parameter int GntLatency = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slave_req_i,
    input  logic [BusWidth-1:0]   slave_add_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    output logic                  slave_gnt_o,
    output logic                  slave_r_valid_o,
    output logic [BusWidth-1:0]   slave_r_rdata_o,
    output logic                  slave_r_err_o
);
    localparam int NumBytes = BusWidth / 8;
    localparam int OffW     = $clog2(NumBytes);
    localparam int IdxW     = $clog2(Depth);
    localparam logic [3:0] CntInit = (GntLatency > 0) ? 4'(GntLatency - 1) : 4'd0;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Stall = 2'd1,
        Resp  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                gnt;
    logic [BusWidth-1:0] rdata_q, rdata_d;
    logic [BusWidth-1:0] mem_q [Depth];
    logic [IdxW-1:0]     idx;
    logic                in_range;
    logic                mem_we;
    logic                unused_add;

    assign idx        = slave_add_i[OffW +: IdxW];
    assign unused_add = ^slave_add_i;

`ifdef DM_SBA_RESP_RANGE_ERR_EN
    logic err_q, err_d;

    assign in_range      = (slave_add_i >> (OffW + IdxW)) == '0;
    assign slave_r_err_o = err_q;

    always_comb begin
        err_d = err_q;
        if (gnt) begin
            err_d = ~in_range;
        end
        if (rst_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        err_q <= err_d;
    end
`else
    // Without range checking every address wraps onto the word array.
    assign in_range      = 1'b1;
    assign slave_r_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            Idle: begin
                if (slave_req_i) begin
                    if (GntLatency == 0) begin
                        gnt     = 1'b1;
                        state_d = Resp;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = Stall;
                    end
                end
            end
            Stall: begin
                if (!slave_req_i) begin
                    state_d = Idle;
                end else if (cnt_q == 4'd0) begin
                    gnt     = 1'b1;
                    state_d = Resp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            Resp:    state_d = Idle;
            default: state_d = Idle;
        endcase
        // Reset wins over everything, including a grant in the same cycle.
        if (rst_i) begin
            gnt     = 1'b0;
            state_d = Idle;
            cnt_d   = 4'd0;
        end
    end

    assign mem_we = gnt & slave_we_i & in_range;

    always_comb begin
        rdata_d = rdata_q;
        if (gnt) begin
            if (slave_we_i || !in_range) begin
                rdata_d = '0;
            end else begin
                rdata_d = mem_q[idx];
            end
        end
        if (rst_i) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rdata_q <= rdata_d;
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (slave_be_i[b]) begin
                    mem_q[idx][b*8 +: 8] <= slave_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign slave_gnt_o     = gnt;
    assign slave_r_valid_o = (state_q == Resp) && !rst_i;
    assign slave_r_rdata_o = rdata_q;
endmodule

// File: tb/tb_dm_sba_resp.sv
// Bench for dm_sba_resp: instance 0 with no wait states, instance 1 with three.
// Responses are checked against an expected queue filled at grant time.
module tb_dm_sba_resp;
  logic        clk;
  logic        rst;
  logic        req0, we0, gnt0, valid0, err0;
  logic [31:0] add0, wdata0, rdata0;
  logic [3:0]  be0;
  logic        req1, we1, gnt1, valid1, err1;
  logic [31:0] add1, wdata1, rdata1;
  logic [3:0]  be1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  typedef struct {
    logic        we;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] model_mem[8];

  dm_sba_resp #(.BusWidth(32), .Depth(256), .GntLatency(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req0), .slave_add_i(add0),
    .slave_we_i(we0), .slave_wdata_i(wdata0), .slave_be_i(be0),
    .slave_gnt_o(gnt0), .slave_r_valid_o(valid0), .slave_r_rdata_o(rdata0),
    .slave_r_err_o(err0)
  );

  dm_sba_resp #(.BusWidth(32), .Depth(256), .GntLatency(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req1), .slave_add_i(add1),
    .slave_we_i(we1), .slave_wdata_i(wdata1), .slave_be_i(be1),
    .slave_gnt_o(gnt1), .slave_r_valid_o(valid1), .slave_r_rdata_o(rdata1),
    .slave_r_err_o(err1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      if (gnt0 || valid0 || gnt1 || valid1)
        check("outputs_low_in_reset", {gnt0, valid0, gnt1, valid1}, 0);
    end else begin
      if (gnt0 && (valid0 || !req0)) check("gnt0_protocol", {valid0, req0}, 2'b01);
      if (gnt1 && (valid1 || !req1)) check("gnt1_protocol", {valid1, req1}, 2'b01);
      if (valid0) begin
        if (exp_q0.size() == 0) begin
          n_checks++;
          $display("FAIL rsp0_unexpected: got r_valid with rdata %h, required no response", rdata0);
        end else begin
          e = exp_q0.pop_front();
          check("rsp0", {err0, rdata0}, e);
        end
      end
      if (valid1) begin
        if (exp_q1.size() == 0) begin
          n_checks++;
          $display("FAIL rsp1_unexpected: got r_valid with rdata %h, required no response", rdata1);
        end else begin
          e = exp_q1.pop_front();
          check("rsp1", {err1, rdata1}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic set_req(input int sel, input logic r, input logic we, input logic [31:0] add,
                         input logic [31:0] wdata, input logic [3:0] be);
    if (sel == 0) begin
      req0 = r; we0 = we; add0 = add; wdata0 = wdata; be0 = be;
    end else begin
      req1 = r; we1 = we; add1 = add; wdata1 = wdata; be1 = be;
    end
  endtask

  // One transaction; exp_wait is the number of request cycles before the grant cycle.
  task automatic run_txn(input int sel, input logic we, input logic [31:0] add,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_wait);
    bit got = 0;
    int n = -1;
    @(posedge clk); #1;
    set_req(sel, 1'b1, we, add, wdata, be);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if ((sel == 0) ? gnt0 : gnt1) begin
        got = 1;
        n = c;
      end
    end
    check("gnt_wait_cycles", n, exp_wait);
    if (got) begin
      if (sel == 0) exp_q0.push_back({exp_err, exp_rd});
      else exp_q1.push_back({exp_err, exp_rd});
      @(posedge clk); #1;
      set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("valid_after_gnt", (sel == 0) ? {valid0, gnt0} : {valid1, gnt1}, 2'b10);
    end else begin
      set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  b;
    logic        w;
    int          k;

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata0_err0", {err0, rdata0}, 0);
    check("reset_rdata1_err1", {err1, rdata1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    tbl[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h020, 32'h11223344, 4'hF, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h020, 32'h0000AA00, 4'h2, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h020, 32'h0,        4'hF, 32'h1122AA44, 1'b0};
    tbl[5]  = '{1'b0, 32'h023, 32'h0,        4'h0, 32'h1122AA44, 1'b0};
    tbl[6]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    tbl[8]  = '{1'b1, 32'h010, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[10] = '{1'b1, 32'h000, 32'h55AA55AA, 4'hF, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 32'h004, 32'h0BADF00D, 4'hF, 32'h0, 1'b0};
`ifdef DM_SBA_RESP_RANGE_ERR_EN
    tbl[12] = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0, 1'b1};
    tbl[13] = '{1'b1, 32'h404, 32'h12345678, 4'hF, 32'h0, 1'b1};
    tbl[14] = '{1'b0, 32'h004, 32'h0,        4'hF, 32'h0BADF00D, 1'b0};
`else
    tbl[12] = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h55AA55AA, 1'b0};
    tbl[13] = '{1'b1, 32'h404, 32'h12345678, 4'hF, 32'h0, 1'b0};
    tbl[14] = '{1'b0, 32'h004, 32'h0,        4'hF, 32'h12345678, 1'b0};
`endif
    tbl[15] = '{1'b0, 32'h01C, 32'h0,        4'hF, 32'h0, 1'b0};
    // Last entry: a read of an unwritten word would be X, so re-read 0x10 instead.
    tbl[15].add    = 32'h010;
    tbl[15].exp_rd = 32'hDEADBEEF;

    for (int i = 0; i < 16; i++)
      run_txn(0, tbl[i].we, tbl[i].add, tbl[i].wdata, tbl[i].be, tbl[i].exp_rd, tbl[i].exp_err, 0);

    // req held across two reads: grants two cycles apart, valid in between
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF);
    @(negedge clk);
    check("b2b_gnt_first", gnt0, 1'b1);
    if (gnt0) exp_q0.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    add0 = 32'h020;
    @(negedge clk);
    check("b2b_resp_cycle", {gnt0, valid0}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    check("b2b_gnt_second", gnt0, 1'b1);
    if (gnt0) exp_q0.push_back({1'b0, 32'h1122AA44});
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("b2b_resp_second", {gnt0, valid0}, 2'b01);

    // reset in the Resp cycle of a read aborts the response
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF);
    @(negedge clk);
    check("rstresp_gnt", gnt0, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rstresp_no_valid", valid0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstresp_rdata_cleared", {err0, rdata0}, 0);
    run_txn(0, 1'b0, 32'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

    // a write requested while in reset must not reach memory
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h010, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    check("rst_blocks_gnt", gnt0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    run_txn(0, 1'b0, 32'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

    // random traffic on words 64..71 against a byte-level model
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model_mem[i] = d;
      run_txn(0, 1'b1, 32'h100 + 32'(i * 4), d, 4'hF, 32'h0, 1'b0, 0);
    end
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 7);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      a = 32'h100 + 32'(k * 4) + 32'($urandom_range(0, 3));
      if (w) begin
        run_txn(0, 1'b1, a, d, b, 32'h0, 1'b0, 0);
        for (int j = 0; j < 4; j++)
          if (b[j]) model_mem[k][j*8 +: 8] = d[j*8 +: 8];
      end else begin
        run_txn(0, 1'b0, a, 32'h0, b, model_mem[k], 1'b0, 0);
      end
    end

    // three wait states: grant on the 4th held request cycle
    run_txn(1, 1'b1, 32'h008, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 3);
    // request withdrawn during Stall: no grant, no response
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 32'h008, 32'h0, 4'hF);
    @(negedge clk);
    check("stall_drop_c1", gnt1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("stall_drop_c2", gnt1, 1'b0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) begin
      @(negedge clk);
      check("stall_drop_quiet", {gnt1, valid1}, 2'b00);
    end
    // a full wait from Idle proves the FSM returned there
    run_txn(1, 1'b0, 32'h008, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 3);
    run_txn(1, 1'b1, 32'h008, 32'h00005A00, 4'h2, 32'h0, 1'b0, 3);
    run_txn(1, 1'b0, 32'h00B, 32'h0, 4'hF, 32'hA5A55AA5, 1'b0, 3);

    repeat (3) @(posedge clk);
    check("queue0_drained", exp_q0.size(), 0);
    check("queue1_drained", exp_q1.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
